multicycle_ctrl: RTL and testbench

- Main control FSM that sequences the RV64I-subset datapath (PC, program memory, register file, ALU, data memory) as a multi-cycle machine.
- Replaces the free-running "PC+4 every clock, externally driven op/flag" arrangement.
- Decodes the IR-captured instruction and drives PC/IR write enables, register write, ALU operand select, the 4-bit ALU op, and memory requests.
- Handles ready handshakes on both memories, traps illegal opcodes and memory timeouts, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV64I-subset datapath: sequences fetch, decode,
// execute, memory and writeback, traps illegal opcodes and memory timeouts.
module multicycle_ctrl #(
  parameter int CNT_W       = 64,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg_write,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam int WD_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             retire;
  logic             wd_hit;

  logic imem_req_c, dmem_req_c, dmem_we_c, ir_write_c, pc_write_c, reg_write_c;

  // Instruction field decode; the IR is stable from DECODE until the next FETCH.
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_add, r_sub, r_and, r_or, is_rtype;
  logic       is_addi, is_ld, is_sd, is_beq, is_legal;
  logic       unused_instr;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  assign r_add    = (opcode == OP_R) && (funct7 == 7'b0000000) && (funct3 == 3'b000);
  assign r_sub    = (opcode == OP_R) && (funct7 == 7'b0100000) && (funct3 == 3'b000);
  assign r_and    = (opcode == OP_R) && (funct7 == 7'b0000000) && (funct3 == 3'b111);
  assign r_or     = (opcode == OP_R) && (funct7 == 7'b0000000) && (funct3 == 3'b110);
  assign is_rtype = r_add | r_sub | r_and | r_or;
  assign is_addi  = (opcode == OP_IMM) && (funct3 == 3'b000);
  assign is_ld    = (opcode == OP_LD)  && (funct3 == 3'b011);
  assign is_sd    = (opcode == OP_ST)  && (funct3 == 3'b011);
  assign is_beq   = (opcode == OP_BR)  && (funct3 == 3'b000);
  assign is_legal = is_rtype | is_addi | is_ld | is_sd | is_beq;

  // The current waiting cycle is the MEM_TIMEOUT-th consecutive one.
  assign wd_hit = (MEM_TIMEOUT > 0) && ((int'(wd_q) + 1) >= MEM_TIMEOUT);

  always_comb begin
    state_d     = state_q;
    wd_d        = '0;
    retire      = 1'b0;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    pc_src      = 1'b0;
    alu_src     = 1'b0;
    alu_op      = ALU_ADD;
    mem_to_reg  = 1'b0;

    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wd_hit) begin
          state_d = S_TRAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_DECODE: begin
        state_d = is_legal ? S_EXEC : S_TRAP;
      end

      S_EXEC: begin
        if (is_rtype) begin
          if (r_sub)      alu_op = ALU_SUB;
          else if (r_and) alu_op = ALU_AND;
          else if (r_or)  alu_op = ALU_OR;
          else            alu_op = ALU_ADD;
          state_d = S_WB;
        end else if (is_addi) begin
          alu_src = 1'b1;
          state_d = S_WB;
        end else if (is_ld || is_sd) begin
          alu_src = 1'b1;
          state_d = S_MEM;
        end else if (is_beq) begin
          alu_op     = ALU_SUB;
          pc_write_c = zero;
          pc_src     = zero;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end

      S_MEM: begin
        alu_src    = 1'b1;
        dmem_req_c = 1'b1;
        dmem_we_c  = is_sd;
        if (mem_ready) begin
          if (is_ld) begin
            state_d = S_WB;
          end else if (is_sd) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_TRAP;
          end
        end else if (wd_hit) begin
          state_d = S_TRAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      S_WB: begin
        reg_write_c = 1'b1;
        mem_to_reg  = is_ld;
        retire      = 1'b1;
        state_d     = S_FETCH;
      end

      S_TRAP: begin
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wd_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
      if (retire) instret_q <= instret_q + CNT_W'(1);
    end
  end

  // Requests and write enables are held low while reset is asserted.
  assign imem_req  = imem_req_c  & rst_n;
  assign dmem_req  = dmem_req_c  & rst_n;
  assign dmem_we   = dmem_we_c   & rst_n;
  assign ir_write  = ir_write_c  & rst_n;
  assign pc_write  = pc_write_c  & rst_n;
  assign reg_write = reg_write_c & rst_n;

  assign illegal = illegal_q;
  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each stimulus cycle queues the hand-derived
// expected control vector; a negedge monitor pops and compares it with the DUT.
module tb_multicycle_ctrl;

  localparam int CNT_W = 4;
  localparam int TO    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      instr;
  logic             zero;
  logic             mem_ready;
  logic             imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic             reg_write, alu_src, mem_to_reg, illegal;
  logic [3:0]       alu_op;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;

  multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .alu_src(alu_src), .alu_op(alu_op),
    .mem_to_reg(mem_to_reg), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef logic [20:0] vec_t;

  // ctl bit order: imem_req dmem_req dmem_we ir_write pc_write pc_src reg_write alu_src
  localparam logic [7:0] C_NONE   = 8'b0000_0000;
  localparam logic [7:0] C_FWAIT  = 8'b1000_0000;
  localparam logic [7:0] C_FACC   = 8'b1001_1000;
  localparam logic [7:0] C_EXI    = 8'b0000_0001;
  localparam logic [7:0] C_BTAKEN = 8'b0000_1100;
  localparam logic [7:0] C_MRD    = 8'b0100_0001;
  localparam logic [7:0] C_MWR    = 8'b0110_0001;
  localparam logic [7:0] C_WB     = 8'b0000_0010;

  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_SUB = 4'b0110;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_AND  = 32'h0020F1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_ADDI = 32'h00808293;
  localparam logic [31:0] I_LD   = 32'h0080B283;
  localparam logic [31:0] I_SD   = 32'h0050B423;
  localparam logic [31:0] I_BEQ  = 32'h00208863;
  localparam logic [31:0] I_BAD  = 32'h0000007F;
  localparam logic [31:0] I_BADR = 32'h4020F1B3;

  vec_t       exp_q[$];
  string      tag_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  logic [3:0] ret;
  vec_t       act;

  assign act = {state, imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
                reg_write, alu_src, alu_op, mem_to_reg, illegal, instret};

  function automatic vec_t mk(input logic [2:0] st, input logic [7:0] ctl,
                              input logic [3:0] aop, input logic m2r,
                              input logic ill, input logic [3:0] r);
    return {st, ctl, aop, m2r, ill, r};
  endfunction

  always @(negedge clk) begin
    vec_t  e;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      compared++;
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: got state=%0d vec=%h, required state=%0d vec=%h",
                 t, act[20:18], act, e[20:18], e);
      end
    end
  end

  task automatic cyc(input string tag, input logic rn, input logic [31:0] ins,
                     input logic z, input logic rdy, input vec_t e);
    rst_n = rn; instr = ins; zero = z; mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input string tag, input logic [31:0] ins, input int waits);
    for (int i = 0; i < waits; i++)
      cyc({tag, ":fwait"}, 1'b1, ins, 1'b0, 1'b0, mk(3'd0, C_FWAIT, A_ADD, 1'b0, 1'b0, ret));
    cyc({tag, ":fetch"}, 1'b1, ins, 1'b0, 1'b1, mk(3'd0, C_FACC, A_ADD, 1'b0, 1'b0, ret));
  endtask

  task automatic decode(input string tag, input logic [31:0] ins);
    cyc({tag, ":decode"}, 1'b1, ins, 1'b1, 1'b1, mk(3'd1, C_NONE, A_ADD, 1'b0, 1'b0, ret));
  endtask

  task automatic run_r(input string tag, input logic [31:0] ins, input logic [3:0] aop);
    fetch(tag, ins, 0);
    decode(tag, ins);
    cyc({tag, ":exec"}, 1'b1, ins, 1'b1, 1'b1, mk(3'd2, C_NONE, aop, 1'b0, 1'b0, ret));
    cyc({tag, ":wb"}, 1'b1, ins, 1'b1, 1'b1, mk(3'd4, C_WB, A_ADD, 1'b0, 1'b0, ret));
    ret = ret + 4'd1;
  endtask

  task automatic run_addi(input string tag);
    fetch(tag, I_ADDI, 0);
    decode(tag, I_ADDI);
    cyc({tag, ":exec"}, 1'b1, I_ADDI, 1'b1, 1'b1, mk(3'd2, C_EXI, A_ADD, 1'b0, 1'b0, ret));
    cyc({tag, ":wb"}, 1'b1, I_ADDI, 1'b0, 1'b1, mk(3'd4, C_WB, A_ADD, 1'b0, 1'b0, ret));
    ret = ret + 4'd1;
  endtask

  task automatic run_ld(input string tag, input int fwaits, input int mwaits);
    fetch(tag, I_LD, fwaits);
    decode(tag, I_LD);
    cyc({tag, ":exec"}, 1'b1, I_LD, 1'b0, 1'b1, mk(3'd2, C_EXI, A_ADD, 1'b0, 1'b0, ret));
    for (int i = 0; i < mwaits; i++)
      cyc({tag, ":mwait"}, 1'b1, I_LD, 1'b0, 1'b0, mk(3'd3, C_MRD, A_ADD, 1'b0, 1'b0, ret));
    cyc({tag, ":mem"}, 1'b1, I_LD, 1'b0, 1'b1, mk(3'd3, C_MRD, A_ADD, 1'b0, 1'b0, ret));
    cyc({tag, ":wb"}, 1'b1, I_LD, 1'b0, 1'b1, mk(3'd4, C_WB, A_ADD, 1'b1, 1'b0, ret));
    ret = ret + 4'd1;
  endtask

  task automatic run_sd(input string tag);
    fetch(tag, I_SD, 0);
    decode(tag, I_SD);
    cyc({tag, ":exec"}, 1'b1, I_SD, 1'b0, 1'b1, mk(3'd2, C_EXI, A_ADD, 1'b0, 1'b0, ret));
    cyc({tag, ":mem"}, 1'b1, I_SD, 1'b0, 1'b1, mk(3'd3, C_MWR, A_ADD, 1'b0, 1'b0, ret));
    ret = ret + 4'd1;
  endtask

  task automatic run_beq(input string tag, input logic z);
    fetch(tag, I_BEQ, 0);
    decode(tag, I_BEQ);
    cyc({tag, ":exec"}, 1'b1, I_BEQ, z, 1'b1,
        mk(3'd2, z ? C_BTAKEN : C_NONE, A_SUB, 1'b0, 1'b0, ret));
    ret = ret + 4'd1;
  endtask

  // TRAP holds with inputs that would otherwise fire enables, then reset releases it.
  task automatic trap_then_reset(input string tag, input logic [31:0] ins);
    for (int i = 0; i < 3; i++)
      cyc({tag, ":trap"}, 1'b1, ins, 1'b1, 1'b1, mk(3'd7, C_NONE, A_ADD, 1'b0, 1'b1, ret));
    cyc({tag, ":rst"}, 1'b0, ins, 1'b1, 1'b1, mk(3'd7, C_NONE, A_ADD, 1'b0, 1'b1, ret));
    ret = 4'd0;
  endtask

  task automatic run_illegal(input string tag, input logic [31:0] ins);
    fetch(tag, ins, 0);
    decode(tag, ins);
    trap_then_reset(tag, ins);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
    ret = 4'd0;
    @(posedge clk);
    #1;
    cyc("reset", 1'b0, 32'h0, 1'b0, 1'b1, mk(3'd0, C_NONE, A_ADD, 1'b0, 1'b0, 4'd0));

    run_r("add", I_ADD, A_ADD);
    run_r("sub", I_SUB, A_SUB);
    run_r("and", I_AND, A_AND);
    run_r("or",  I_OR,  A_OR);
    run_addi("addi");
    run_ld("ld_m3", 0, 3);
    run_ld("ld_f3m3", 3, 3);
    run_sd("sd");
    run_beq("beq_t", 1'b1);
    run_beq("beq_nt", 1'b0);

    run_illegal("bad_op", I_BAD);
    run_illegal("bad_r", I_BADR);

    run_addi("pre_fwd");
    for (int i = 0; i < TO; i++)
      cyc("fwd:wait", 1'b1, I_ADDI, 1'b0, 1'b0, mk(3'd0, C_FWAIT, A_ADD, 1'b0, 1'b0, ret));
    trap_then_reset("fwd", I_ADDI);

    fetch("mwd", I_SD, 0);
    decode("mwd", I_SD);
    cyc("mwd:exec", 1'b1, I_SD, 1'b0, 1'b1, mk(3'd2, C_EXI, A_ADD, 1'b0, 1'b0, ret));
    for (int i = 0; i < TO; i++)
      cyc("mwd:wait", 1'b1, I_SD, 1'b0, 1'b0, mk(3'd3, C_MWR, A_ADD, 1'b0, 1'b0, ret));
    trap_then_reset("mwd", I_SD);

    run_addi("pre_mrst");
    fetch("mrst", I_LD, 0);
    decode("mrst", I_LD);
    cyc("mrst:exec", 1'b1, I_LD, 1'b0, 1'b1, mk(3'd2, C_EXI, A_ADD, 1'b0, 1'b0, ret));
    cyc("mrst:mwait", 1'b1, I_LD, 1'b0, 1'b0, mk(3'd3, C_MRD, A_ADD, 1'b0, 1'b0, ret));
    cyc("mrst:rst", 1'b0, I_LD, 1'b0, 1'b0, mk(3'd3, C_EXI, A_ADD, 1'b0, 1'b0, ret));
    ret = 4'd0;
    cyc("mrst:after", 1'b1, I_LD, 1'b0, 1'b0, mk(3'd0, C_FWAIT, A_ADD, 1'b0, 1'b0, 4'd0));

    for (int i = 0; i < 17; i++) run_addi("wrap_addi");
    cyc("wrap", 1'b1, I_ADDI, 1'b0, 1'b0, mk(3'd0, C_FWAIT, A_ADD, 1'b0, 1'b0, 4'd1));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
